// File: rtl/digit_value_editor_if.sv
// Pulse inputs and registered display outputs of one BCD digit editor.
interface digit_value_editor_if #(
  parameter int unsigned NDIGITS = 4
);
  localparam int unsigned CW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  logic                   digitchange;
  logic                   digitinc;
  logic                   digitreset;
  logic                   valuereset;
  logic                   load;
  logic [4*NDIGITS-1:0]   load_value;
  logic [4*NDIGITS-1:0]   value;
  logic [CW-1:0]          cursor;
  logic [NDIGITS-1:0]     blink_mask;
  logic                   changed;

  modport master (
    output digitchange, digitinc, digitreset, valuereset, load, load_value,
    input  value, cursor, blink_mask, changed
  );

  modport slave (
    input  digitchange, digitinc, digitreset, valuereset, load, load_value,
    output value, cursor, blink_mask, changed
  );
endinterface

// File: rtl/digit_value_editor.sv
// Cursor-based BCD value editor with blinking highlight of the selected digit.
module digit_value_editor #(
  parameter int unsigned NDIGITS    = 4,
  parameter int unsigned BLINK_BITS = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  digit_value_editor_if.slave  bus
);
  localparam int unsigned CW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int unsigned VW = 4 * NDIGITS;

  logic [VW-1:0]         value_q, value_d;
  logic [CW-1:0]         cursor_q, cursor_d;
  logic [BLINK_BITS-1:0] blink_q, blink_d;
  logic [NDIGITS-1:0]    mask_q, mask_d;
  logic                  changed_q, changed_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q   <= '0;
      cursor_q  <= '0;
      blink_q   <= '0;
      mask_q    <= NDIGITS'(1);
      changed_q <= 1'b0;
    end else begin
      value_q   <= value_d;
      cursor_q  <= cursor_d;
      blink_q   <= blink_d;
      mask_q    <= mask_d;
      changed_q <= changed_d;
    end
  end

  always_comb begin
    value_d   = value_q;
    cursor_d  = cursor_q;
    blink_d   = blink_q + BLINK_BITS'(1);
    mask_d    = '0;
    changed_d = bus.valuereset | bus.load | bus.digitreset | bus.digitinc;

    // Only the highest-priority edit is applied, always at the current cursor.
    if (bus.valuereset) begin
      value_d = '0;
    end else if (bus.load) begin
      value_d = bus.load_value;
    end else if (bus.digitreset || bus.digitinc) begin
      for (int i = 0; i < NDIGITS; i++) begin
        if (CW'(i) == cursor_q) begin
          if (bus.digitreset || (value_q[4*i +: 4] >= 4'd9))
            value_d[4*i +: 4] = 4'd0;
          else
            value_d[4*i +: 4] = value_q[4*i +: 4] + 4'd1;
        end
      end
    end

    if (bus.valuereset)
      cursor_d = '0;
    else if (bus.digitchange)
      cursor_d = (cursor_q == CW'(NDIGITS - 1)) ? '0 : cursor_q + CW'(1);

    if (changed_d || bus.digitchange)
      blink_d = '0;

    // Highlight is on during the first half period after a user action.
    if (!blink_d[BLINK_BITS-1])
      mask_d = NDIGITS'(1) << cursor_d;
  end

  assign bus.value      = value_q;
  assign bus.cursor     = cursor_q;
  assign bus.blink_mask = mask_q;
  assign bus.changed    = changed_q;
endmodule

// File: tb/tb_digit_value_editor.sv
// Directed scoreboard bench for digit_value_editor (NDIGITS=4, BLINK_BITS=3).
module tb_digit_value_editor;
  logic clk;
  logic reset;

  digit_value_editor_if #(.NDIGITS(4)) bus ();

  digit_value_editor #(.NDIGITS(4), .BLINK_BITS(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] value;
    logic [1:0]  cursor;
    logic [3:0]  mask;
    logic        changed;
  } exp_t;

  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          chg_seen = 0;
  logic [15:0] m_value;
  logic [1:0]  m_cursor;
  logic [2:0]  m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_value  = '0;
    m_cursor = '0;
    m_cnt    = '0;
    sb.delete();
  endtask

  // Drive one cycle of pulses, push the predicted outputs, then compare after the edge.
  task automatic drive(input logic dc, di, dr, vr, ld, input logic [15:0] lv);
    exp_t e;
    logic [3:0] d;
    @(negedge clk);
    bus.digitchange = dc; bus.digitinc = di; bus.digitreset = dr;
    bus.valuereset  = vr; bus.load     = ld; bus.load_value = lv;
    if (vr) m_value = '0;
    else if (ld) m_value = lv;
    else if (dr || di) begin
      d = m_value[4*m_cursor +: 4];
      d = (dr || d >= 4'd9) ? 4'd0 : d + 4'd1;
      m_value[4*m_cursor +: 4] = d;
    end
    if (vr) m_cursor = 2'd0;
    else if (dc) m_cursor = m_cursor + 2'd1;
    m_cnt = (dc || di || dr || vr || ld) ? 3'd0 : m_cnt + 3'd1;
    e.value   = m_value;
    e.cursor  = m_cursor;
    e.mask    = m_cnt[2] ? 4'b0000 : (4'b0001 << m_cursor);
    e.changed = di | dr | vr | ld;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.digitchange = 1'b0; bus.digitinc = 1'b0; bus.digitreset = 1'b0;
    bus.valuereset  = 1'b0; bus.load     = 1'b0;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("value",   32'(bus.value),      32'(e.value));
      check("cursor",  32'(bus.cursor),     32'(e.cursor));
      check("mask",    32'(bus.blink_mask), 32'(e.mask));
      check("changed", 32'(bus.changed),    32'(e.changed));
    end
    if (bus.changed) chg_seen++;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    bus.digitchange = 1'b0; bus.digitinc = 1'b0; bus.digitreset = 1'b0;
    bus.valuereset  = 1'b0; bus.load     = 1'b0; bus.load_value = '0;
    reset = 1'b1;
    model_reset();
    #1;
    check("rst_value",   32'(bus.value),      32'h0);
    check("rst_cursor",  32'(bus.cursor),     32'h0);
    check("rst_mask",    32'(bus.blink_mask), 32'h1);
    check("rst_changed", 32'(bus.changed),    32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Cursor and increment
    chg_seen = 0;
    repeat (3) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    repeat (12) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    check("s1_value",  32'(bus.value),  32'h0023);
    check("s1_cursor", 32'(bus.cursor), 32'h1);
    check("s1_pulses", 32'(chg_seen),   32'd15);
    idle();
    check("s1_changed_drop", 32'(bus.changed), 32'h0);

    // Wrap-around
    repeat (2) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h9999);
    check("s2_load", 32'(bus.value), 32'h9999);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    check("s2_wrap_digit", 32'(bus.value), 32'h0999);
    repeat (4) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    check("s2_cursor", 32'(bus.cursor), 32'h3);
    check("s2_no_chg", 32'(bus.changed), 32'h0);

    // Simultaneous events
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0005);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    check("s3_value",  32'(bus.value),  32'h0006);
    check("s3_cursor", 32'(bus.cursor), 32'h1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h1234);
    check("s3_load_prio", 32'(bus.value), 32'h1234);

    // Priority: valuereset beats load and digitchange
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h4321);
    check("s4_value",   32'(bus.value),   32'h0);
    check("s4_cursor",  32'(bus.cursor),  32'h0);
    check("s4_changed", 32'(bus.changed), 32'h1);
    idle();
    check("s4_one_cycle", 32'(bus.changed), 32'h0);

    // Non-BCD load and blink timing
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h00F0);
    check("s5_raw_load", 32'(bus.value), 32'h00F0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    check("s5_digit1", 32'(bus.value),      32'h0000);
    check("s5_mask0",  32'(bus.blink_mask), 32'h4);
    repeat (3) idle();
    check("s5_mask_on", 32'(bus.blink_mask), 32'h4);
    idle();
    check("s5_mask_off", 32'(bus.blink_mask), 32'h0);
    repeat (3) idle();
    check("s5_mask_off_end", 32'(bus.blink_mask), 32'h0);
    idle();
    check("s5_mask_wrap", 32'(bus.blink_mask), 32'h4);
    repeat (5) idle();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    check("s5_restart", 32'(bus.blink_mask), 32'h8);

    // Reset mid-operation
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5678);
    @(negedge clk);
    bus.digitinc = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("s6_async_value",   32'(bus.value),      32'h0);
    check("s6_async_cursor",  32'(bus.cursor),     32'h0);
    check("s6_async_mask",    32'(bus.blink_mask), 32'h1);
    check("s6_async_changed", 32'(bus.changed),    32'h0);
    @(posedge clk);
    #1;
    check("s6_hold_value", 32'(bus.value), 32'h0);
    @(negedge clk);
    bus.digitinc = 1'b0;
    reset = 1'b0;
    idle();
    check("s6_no_changed", 32'(bus.changed), 32'h0);
    check("s6_value_zero", 32'(bus.value),   32'h0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    check("s6_post_inc", 32'(bus.value), 32'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
